// File: rtl/avalon_multi_timer_pkg.sv
// rtl/avalon_multi_timer_pkg.sv - register map constants for the multi-channel timer
package avalon_multi_timer_pkg;
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_IE    = 2;
    localparam int CTRL_START = 3;

    localparam int STATUS_TO  = 0;
endpackage

// File: rtl/avalon_multi_timer_channel.sv
// rtl/avalon_multi_timer_channel.sv - one timer channel: registers, decrement/reload, timeout pulse
module timer_channel
    import avalon_multi_timer_pkg::*;
#(
    parameter int WIDTH = 32
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             wr_ctrl,
    input  logic             wr_period,
    input  logic             wr_count,
    input  logic             wr_status,
    input  logic [WIDTH-1:0] wdata,
    output logic             en,
    output logic             cont,
    output logic             ie,
    output logic             to,
    output logic             pulse,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] count
);
    logic start;
    logic run;
    logic timeout;

    // A START load pre-empts the tick in the same cycle, so no decrement or timeout then.
    assign start   = wr_ctrl & wdata[CTRL_START];
    assign run     = tick & en & ~start;
    assign timeout = run & (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en     <= 1'b0;
            cont   <= 1'b0;
            ie     <= 1'b0;
            to     <= 1'b0;
            pulse  <= 1'b0;
            period <= '0;
            count  <= '0;
        end else begin
            pulse <= timeout;

            if (wr_period)
                period <= wdata;

            if (start)
                count <= period;
            else if (wr_count)
                count <= wdata;
            else if (timeout)
                count <= cont ? period : '0;
            else if (run)
                count <= count - WIDTH'(1);

            // A CTRL write decides the final EN even when a timeout lands in the same cycle.
            if (wr_ctrl) begin
                en   <= wdata[CTRL_EN];
                cont <= wdata[CTRL_CONT];
                ie   <= wdata[CTRL_IE];
            end else if (timeout && !cont) begin
                en <= 1'b0;
            end

            if (timeout)
                to <= 1'b1;
            else if (wr_status && wdata[STATUS_TO])
                to <= 1'b0;
        end
    end
endmodule

// File: rtl/avalon_multi_timer.sv
// rtl/avalon_multi_timer.sv - Avalon-MM multi-channel down-counting timer with shared prescaler
module avalon_multi_timer
    import avalon_multi_timer_pkg::*;
#(
    parameter int  NUM_CHANNELS = 4,
    parameter int  WIDTH        = 32,
    parameter int  TICK_DIV     = 1,
    localparam int ADDR_W       = $clog2(NUM_CHANNELS) + 2
)(
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    input  logic [ADDR_W-1:0]       avs_address,
    input  logic                    avs_chipselect,
    input  logic                    avs_write,
    input  logic [31:0]             avs_writedata,
    input  logic                    avs_read,
    output logic [31:0]             avs_readdata,
    output logic                    irq,
    output logic [NUM_CHANNELS-1:0] timeout_pulse
);
    localparam int CH_W = (ADDR_W > 2) ? ADDR_W - 2 : 1;
    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PS_W-1:0]         presc;
    logic                    tick;
    logic [CH_W+1:0]         addr_x;
    logic [CH_W-1:0]         ch_sel;
    logic [1:0]              reg_sel;
    logic                    wr_en;
    logic [31:0]             rd_word;
    logic [NUM_CHANNELS-1:0] en, cont, ie, to;
    logic [WIDTH-1:0]        period [NUM_CHANNELS];
    logic [WIDTH-1:0]        count  [NUM_CHANNELS];

    // Zero-extend so a single-channel build still has a channel field to compare against.
    assign addr_x  = (CH_W+2)'(avs_address);
    assign ch_sel  = addr_x[CH_W+1:2];
    assign reg_sel = addr_x[1:0];
    assign wr_en   = avs_chipselect & avs_write;
    assign tick    = (presc == PS_W'(TICK_DIV - 1));

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)
            presc <= '0;
        else
            presc <= tick ? '0 : presc + PS_W'(1);
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        logic hit;
        assign hit = wr_en & (ch_sel == CH_W'(i));

        timer_channel #(.WIDTH(WIDTH)) u_ch (
            .clk       (clk_clk),
            .rst_n     (reset_reset_n),
            .tick      (tick),
            .wr_ctrl   (hit & (reg_sel == REG_CTRL)),
            .wr_period (hit & (reg_sel == REG_PERIOD)),
            .wr_count  (hit & (reg_sel == REG_COUNT)),
            .wr_status (hit & (reg_sel == REG_STATUS)),
            .wdata     (avs_writedata[WIDTH-1:0]),
            .en        (en[i]),
            .cont      (cont[i]),
            .ie        (ie[i]),
            .to        (to[i]),
            .pulse     (timeout_pulse[i]),
            .period    (period[i]),
            .count     (count[i])
        );
    end

    // Unpopulated channel slots never match, so they read back as zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (ch_sel == CH_W'(i)) begin
                case (reg_sel)
                    REG_CTRL:   rd_word = {29'd0, ie[i], cont[i], en[i]};
                    REG_PERIOD: rd_word = 32'(period[i]);
                    REG_COUNT:  rd_word = 32'(count[i]);
                    default:    rd_word = {31'd0, to[i]};
                endcase
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)
            avs_readdata <= '0;
        else if (avs_chipselect && avs_read)
            avs_readdata <= rd_word;
    end

    assign irq = |(to & ie);
endmodule

// File: tb/tb_avalon_multi_timer.sv
// tb/tb_avalon_multi_timer.sv - self-checking bench for avalon_multi_timer
module tb_avalon_multi_timer;
    logic        clk;
    logic        rst_n;
    logic [1:0]  cs;
    logic [3:0]  addr;
    logic        wr, rd;
    logic [31:0] wdata;
    logic [31:0] rdata_a, rdata_b;
    logic        irq_a, irq_b;
    logic [2:0]  pulse_a;
    logic [3:0]  pulse_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    avalon_multi_timer #(.NUM_CHANNELS(3), .WIDTH(32), .TICK_DIV(1)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(addr), .avs_chipselect(cs[0]),
        .avs_write(wr), .avs_writedata(wdata), .avs_read(rd), .avs_readdata(rdata_a),
        .irq(irq_a), .timeout_pulse(pulse_a));

    avalon_multi_timer #(.NUM_CHANNELS(4), .WIDTH(32), .TICK_DIV(3)) dut3 (
        .clk_clk(clk), .reset_reset_n(rst_n), .avs_address(addr), .avs_chipselect(cs[1]),
        .avs_write(wr), .avs_writedata(wdata), .avs_read(rd), .avs_readdata(rdata_b),
        .irq(irq_b), .timeout_pulse(pulse_b));

    typedef struct { bit inst; logic [31:0] exp; string name; } rd_exp_t;
    typedef struct { bit inst; bit is_wr; logic [3:0] a; logic [31:0] data; string name; } vec_t;

    rd_exp_t sb[$];
    vec_t    vt[$];
    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: every read pushes its expectation; the returned word is compared here.
    always @(posedge clk) begin
        rd_exp_t e;
        if (|cs && rd) begin
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.name, e.inst ? rdata_b : rdata_a, e.exp);
            end else begin
                errors++;
                $display("FAIL sb_underflow: read with no expectation queued");
            end
        end
    end

    function automatic logic [3:0] ra(int ch, int r);
        return 4'((ch << 2) | r);
    endfunction

    task automatic bus_wr(bit inst, logic [3:0] a, logic [31:0] d);
        cs = inst ? 2'b10 : 2'b01; addr = a; wdata = d; wr = 1'b1;
        @(negedge clk);
        cs = 2'b00; wr = 1'b0;
    endtask

    task automatic bus_rd(bit inst, logic [3:0] a, logic [31:0] exp, string name);
        rd_exp_t e;
        e.inst = inst; e.exp = exp; e.name = name;
        sb.push_back(e);
        cs = inst ? 2'b10 : 2'b01; addr = a; rd = 1'b1;
        @(negedge clk);
        cs = 2'b00; rd = 1'b0;
    endtask

    task automatic wait_pulse3(output int at);
        at = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (pulse_b[3]) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++; errors++;
            $display("FAIL wait_pulse3: no pulse within 40 cycles");
        end
    endtask

    function automatic void add(bit inst, bit is_wr, logic [3:0] a, logic [31:0] d, string n);
        vec_t v;
        v.inst = inst; v.is_wr = is_wr; v.a = a; v.data = d; v.name = n;
        vt.push_back(v);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int npulse, at, irq_seen, p1, p2, p3, p4, p5;
        rst_n = 1'b0; cs = 2'b00; addr = '0; wr = 1'b0; rd = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({irq_a, irq_b, pulse_a, pulse_b}), 32'd0);
        check("reset_rdata_a", rdata_a, 32'd0);
        check("reset_rdata_b", rdata_b, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Continuous mode, ch0, PERIOD 4 -> timeout every 5 clocks
        bus_wr(0, ra(0, 1), 32'd4);
        bus_wr(0, ra(0, 0), 32'hF);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("cont_pulse_k%0d", k), 32'(pulse_a[0]), 32'((k % 5) == 0));
        end
        check("cont_irq", 32'(irq_a), 32'd1);
        bus_rd(0, ra(0, 3), 32'd1, "cont_status");
        bus_wr(0, ra(0, 3), 32'd1);
        check("cont_irq_cleared", 32'(irq_a), 32'd0);
        @(negedge clk);
        check("cont_irq_reassert", 32'(irq_a), 32'd1);
        check("cont_pulse_reassert", 32'(pulse_a[0]), 32'd1);
        bus_wr(0, ra(0, 0), 32'd0);
        bus_wr(0, ra(0, 3), 32'd1);
        check("cont_stop_irq", 32'(irq_a), 32'd0);

        // One-shot, ch1, PERIOD 2 -> single pulse 3 clocks after START
        bus_wr(0, ra(1, 1), 32'd2);
        bus_wr(0, ra(1, 0), 32'h9);
        npulse = 0; at = -1; irq_seen = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (pulse_a[1]) begin npulse++; at = k; end
            if (irq_a) irq_seen = 1;
        end
        check("oneshot_npulse", 32'(npulse), 32'd1);
        check("oneshot_at", 32'(at), 32'd3);
        check("oneshot_irq", 32'(irq_seen), 32'd0);
        bus_rd(0, ra(1, 0), 32'd0, "oneshot_ctrl");
        bus_rd(0, ra(1, 2), 32'd0, "oneshot_count");
        bus_rd(0, ra(1, 3), 32'd1, "oneshot_status");
        bus_wr(0, ra(1, 3), 32'd1);

        // Collision: STATUS clear on the timeout edge, then START on a tick
        bus_wr(0, ra(2, 1), 32'd2);
        bus_wr(0, ra(2, 0), 32'hB);
        repeat (2) @(negedge clk);
        bus_wr(0, ra(2, 3), 32'd1);
        check("coll_pulse", 32'(pulse_a[2]), 32'd1);
        bus_rd(0, ra(2, 3), 32'd1, "coll_status_set_wins");
        bus_wr(0, ra(2, 0), 32'hB);
        bus_rd(0, ra(2, 2), 32'd2, "start_on_tick_count");
        bus_wr(0, ra(2, 0), 32'd0);
        bus_wr(0, ra(2, 3), 32'd1);

        // Prescaler 3, ch3 PERIOD 1 -> 6 clocks; PERIOD 3 mid-count -> 12 clocks from next reload
        bus_wr(1, ra(3, 1), 32'd1);
        bus_wr(1, ra(3, 0), 32'hB);
        wait_pulse3(p1);
        wait_pulse3(p2);
        check("ps_interval_6", 32'(p2 - p1), 32'd6);
        repeat (2) @(negedge clk);
        bus_wr(1, ra(3, 1), 32'd3);
        wait_pulse3(p3);
        check("ps_interval_unchanged", 32'(p3 - p2), 32'd6);
        wait_pulse3(p4);
        check("ps_interval_12a", 32'(p4 - p3), 32'd12);
        wait_pulse3(p5);
        check("ps_interval_12b", 32'(p5 - p4), 32'd12);

        // Reset mid-run with irq asserted and dut3 still counting
        bus_wr(0, ra(0, 0), 32'hF);
        repeat (7) @(negedge clk);
        check("prereset_irq", 32'(irq_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_async_irq", 32'(irq_a), 32'd0);
        irq_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (irq_a || irq_b || |pulse_a || |pulse_b) irq_seen = 1;
        end
        check("reset_quiet", 32'(irq_seen), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Register table: reset values, R/W, out-of-range channel, no aliasing
        for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < 4; r++)
                add(0, 0, ra(ch, r), 32'd0, $sformatf("rst_rd_ch%0d_r%0d", ch, r));
        for (int r = 0; r < 4; r++)
            add(1, 0, ra(3, r), 32'd0, $sformatf("rst_rd3_r%0d", r));
        add(0, 1, ra(0, 1), 32'hDEADBEEF, "");
        add(0, 0, ra(0, 1), 32'hDEADBEEF, "period_rw");
        add(0, 1, ra(3, 1), 32'h55, "");
        add(0, 0, ra(3, 1), 32'd0, "oor_period_rd");
        add(0, 1, ra(3, 0), 32'hF, "");
        add(0, 0, ra(3, 0), 32'd0, "oor_ctrl_rd");
        add(0, 0, ra(3, 3), 32'd0, "oor_status_rd");
        add(0, 0, ra(0, 1), 32'hDEADBEEF, "period_intact");
        add(0, 0, ra(0, 0), 32'd0, "ch0_ctrl_intact");
        add(0, 1, ra(1, 2), 32'h1234, "");
        add(0, 0, ra(1, 2), 32'h1234, "count_wr");
        add(0, 1, ra(1, 0), 32'hE, "");
        add(0, 0, ra(1, 0), 32'h6, "ctrl_start_reads_0");
        add(0, 0, ra(1, 2), 32'd0, "start_loads_period");
        add(0, 1, ra(1, 1), 32'hFFFFFFFF, "");
        add(0, 0, ra(1, 1), 32'hFFFFFFFF, "period_full");
        add(1, 1, ra(2, 1), 32'hA5A5, "");
        add(1, 0, ra(2, 1), 32'hA5A5, "dut3_period");
        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].is_wr) bus_wr(vt[i].inst, vt[i].a, vt[i].data);
            else             bus_rd(vt[i].inst, vt[i].a, vt[i].data, vt[i].name);
        end
        repeat (3) @(negedge clk);
        check("rdata_hold_a", rdata_a, 32'hFFFFFFFF);
        check("rdata_hold_b", rdata_b, 32'hA5A5);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
